// File: rtl/irq_ctl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctl
// Description : Masked, fixed-priority interrupt controller with a single CPU
//               interrupt line, ack/EOI handshake and per-source clear pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctl #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_req,
    output logic [N_SRC-1:0] src_clr,
    output logic             cpu_irq,
    input  logic             cpu_ack,
    input  logic [1:0]       addr,
    input  logic [31:0]      din,
    input  logic             wr,
    output logic [31:0]      dout
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_SVC  = 2'd2;
    localparam logic [1:0] c_CLR  = 2'd3;

    localparam logic [1:0] c_ADDR_MASK = 2'd0;
    localparam logic [1:0] c_ADDR_PEND = 2'd1;
    localparam logic [1:0] c_ADDR_VEC  = 2'd2;
    localparam logic [1:0] c_ADDR_EOI  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [N_SRC-1:0] r_mask;
    logic [2:0]       r_vec;
    logic [2:0]       w_vec_next;
    logic             r_irq;
    logic [N_SRC-1:0] r_clr;

    logic [N_SRC-1:0] w_active;
    logic [2:0]       w_sel;
    logic [N_SRC-1:0] w_vec_onehot;
    logic             w_vec_enabled;
    logic             w_eoi_wr;
    logic             w_mask_wr;
    logic             w_in_service;
    logic             w_unused_din;

    assign w_active  = src_req & r_mask;
    assign w_eoi_wr  = wr && (addr == c_ADDR_EOI);
    assign w_mask_wr = wr && (addr == c_ADDR_MASK);

    // Lowest set bit wins: scan from the top so lower indices overwrite.
    always_comb begin
        w_sel = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) w_sel = 3'(i);
        end
    end

    always_comb begin
        w_vec_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_vec_onehot[i] = (r_vec == 3'(i));
        end
    end

    assign w_vec_enabled = |(w_vec_onehot & r_mask);

    always_comb begin
        w_next     = r_state;
        w_vec_next = r_vec;
        case (r_state)
            c_IDLE: begin
                if (|w_active) begin
                    w_vec_next = w_sel;
                    w_next     = c_REQ;
                end
            end
            c_REQ: begin
                // Ack takes precedence over a withdrawn mask bit.
                if (cpu_ack)             w_next = c_SVC;
                else if (!w_vec_enabled) w_next = c_IDLE;
            end
            c_SVC: begin
                if (w_eoi_wr) w_next = c_CLR;
            end
            c_CLR: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_mask  <= '0;
            r_vec   <= 3'd0;
            r_irq   <= 1'b0;
            r_clr   <= '0;
        end else begin
            r_state <= w_next;
            r_vec   <= w_vec_next;
            r_irq   <= (w_next == c_REQ);
            r_clr   <= (w_next == c_CLR) ? w_vec_onehot : '0;
            if (w_mask_wr) r_mask <= din[N_SRC-1:0];
        end
    end

    assign cpu_irq = r_irq;
    assign src_clr = r_clr;

    assign w_in_service = (r_state == c_SVC) || (r_state == c_CLR);

    always_comb begin
        dout = 32'd0;
        case (addr)
            c_ADDR_MASK: dout = {{(32 - N_SRC){1'b0}}, r_mask};
            c_ADDR_PEND: dout = {{(32 - N_SRC){1'b0}}, src_req};
            c_ADDR_VEC:  dout = {w_in_service, 28'd0, r_vec};
            default:     dout = 32'd0;
        endcase
    end

    // Only the low N_SRC data bits carry meaning on this bus.
    assign w_unused_din = ^din;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctl
// Description : Self-checking bench for irq_ctl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctl;

    localparam int N_SRC = 4;

    localparam int c_P_IDLE = 0;
    localparam int c_P_WAIT_ACK = 1;
    localparam int c_P_SERVICE = 2;
    localparam int c_P_CLEAR = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] src_req;
    logic [N_SRC-1:0] src_clr;
    logic             cpu_irq;
    logic             cpu_ack;
    logic [1:0]       addr;
    logic [31:0]      din;
    logic             wr;
    logic [31:0]      dout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_ph;
    logic [3:0] m_mask;
    logic [2:0] m_vec;

    irq_ctl #(.N_SRC(N_SRC)) dut (
        .clk     (clk),
        .rst     (rst),
        .src_req (src_req),
        .src_clr (src_clr),
        .cpu_irq (cpu_irq),
        .cpu_ack (cpu_ack),
        .addr    (addr),
        .din     (din),
        .wr      (wr),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_irq();
        return (m_ph == c_P_WAIT_ACK);
    endfunction

    function automatic logic [3:0] exp_clr();
        return (m_ph == c_P_CLEAR) ? (4'b0001 << m_vec) : 4'b0000;
    endfunction

    function automatic logic [31:0] exp_dout();
        logic busy;
        busy = (m_ph == c_P_SERVICE) || (m_ph == c_P_CLEAR);
        case (addr)
            2'd0:    return {28'd0, m_mask};
            2'd1:    return {28'd0, src_req};
            2'd2:    return {busy, 28'd0, m_vec};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the controller's behaviour, computed from the rules.
    task automatic model_step();
        logic [3:0] act;
        logic [3:0] lowest;
        int         nph;
        if (rst) begin
            m_ph   = c_P_IDLE;
            m_mask = 4'd0;
            m_vec  = 3'd0;
        end else begin
            act = src_req & m_mask;
            nph = m_ph;
            if (m_ph == c_P_IDLE) begin
                if (act != 4'd0) begin
                    lowest = act & (-act);
                    m_vec  = 3'($clog2(lowest));
                    nph    = c_P_WAIT_ACK;
                end
            end else if (m_ph == c_P_WAIT_ACK) begin
                if (cpu_ack) nph = c_P_SERVICE;
                else if (((m_mask >> m_vec) & 4'd1) == 4'd0) nph = c_P_IDLE;
            end else if (m_ph == c_P_SERVICE) begin
                if (wr && addr == 2'd3) nph = c_P_CLEAR;
            end else begin
                nph = c_P_IDLE;
            end
            m_ph = nph;
            if (wr && addr == 2'd0) m_mask = din[3:0];
        end
    endtask

    // Check outputs mid-cycle, advance one edge, then release pulses and let
    // the sticky source flops drop whatever was just cleared.
    task automatic tick();
        logic [3:0] clr_now;
        @(negedge clk);
        check_val("cpu_irq", {31'd0, cpu_irq}, {31'd0, exp_irq()});
        check_val("src_clr", {28'd0, src_clr}, {28'd0, exp_clr()});
        check_val("dout", dout, exp_dout());
        clr_now = rst ? 4'd0 : exp_clr();
        @(posedge clk);
        model_step();
        #1;
        src_req = src_req & ~clr_now;
        wr      = 1'b0;
        cpu_ack = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        wr   = 1'b1;
        addr = a;
        din  = d;
        tick();
    endtask

    initial begin
        rst = 1'b1; src_req = 4'd0; cpu_ack = 1'b0; addr = 2'd0; din = 32'd0; wr = 1'b0;
        m_ph = c_P_IDLE; m_mask = 4'd0; m_vec = 3'd0;
        tick();
        rst = 1'b1;
        tick();

        // Register reads after reset
        src_req = 4'b0000;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            tick();
        end
        addr = 2'd0;
        #1 check_val("rst_mask", dout, 32'd0);

        // Single source service with full handshake
        src_req = 4'b0100;
        reg_write(2'd0, 32'h0000_0004);
        addr = 2'd2;
        tick();
        check_val("req_irq", {31'd0, cpu_irq}, 32'd1);
        check_val("req_vec", dout, 32'h0000_0002);
        cpu_ack = 1'b1;
        tick();
        check_val("ack_irq", {31'd0, cpu_irq}, 32'd0);
        check_val("ack_vec", dout, 32'h8000_0002);
        tick();
        reg_write(2'd3, 32'hdead_beef);
        check_val("eoi_clr", {28'd0, src_clr}, 32'h4);
        addr = 2'd2;
        tick();
        check_val("post_clr", {28'd0, src_clr}, 32'h0);
        tick();

        // Priority and back-to-back service
        src_req = 4'b1010;
        reg_write(2'd0, 32'h0000_000f);
        addr = 2'd2;
        tick();
        check_val("prio_vec", dout, 32'h0000_0001);
        cpu_ack = 1'b1;
        tick();
        reg_write(2'd3, 32'd0);
        addr = 2'd2;
        tick();
        tick();
        check_val("b2b_irq", {31'd0, cpu_irq}, 32'd1);
        check_val("b2b_vec", dout, 32'h0000_0003);
        cpu_ack = 1'b1;
        tick();
        reg_write(2'd3, 32'd0);
        tick();
        tick();

        // Withdrawing the mask in REQ without an ack
        src_req = 4'b0100;
        tick();
        reg_write(2'd0, 32'd0);
        tick();
        check_val("unmask_irq", {31'd0, cpu_irq}, 32'd0);
        tick();
        tick();

        // Ignored ack and EOI, then reset during service
        cpu_ack = 1'b1;
        tick();
        reg_write(2'd0, 32'h0000_0004);
        tick();
        reg_write(2'd3, 32'd0);
        check_val("eoi_in_req", {31'd0, cpu_irq}, 32'd1);
        cpu_ack = 1'b1;
        tick();
        rst  = 1'b1;
        addr = 2'd0;
        tick();
        check_val("rst_svc_irq", {31'd0, cpu_irq}, 32'd0);
        check_val("rst_svc_mask", dout, 32'd0);
        tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) src_req = src_req | 4'(1 << $urandom_range(0, 3));
            cpu_ack = ($urandom_range(0, 3) == 0);
            addr    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                wr  = 1'b1;
                din = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
